// File: rtl/reorder_buffer_commit.sv
// reorder_buffer_commit
//   Circular in-order reorder buffer. Allocates a tag per issued instruction,
//   captures CDB results, and retires at most one entry per cycle in program
//   order, driving the RegisterFile write port.
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (global enable), clear_in (flush)
//   issue_valid/issue_has_rd/issue_rd  -> allocation request
//   issue_tag, rob_full, rob_empty     <- allocation status (combinational)
//   cdb_valid/cdb_tag/cdb_value        -> result broadcast
//   to_reg_wen/to_reg_rd/to_reg_wdata  <- registered register-file write
//   commit_valid/commit_tag            <- registered retire pulse
module reorder_buffer_commit #(
  parameter int unsigned ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 issue_valid,
  input  logic                 issue_has_rd,
  input  logic [4:0]           issue_rd,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 rob_full,
  output logic                 rob_empty,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  output logic                 to_reg_wen,
  output logic [4:0]           to_reg_rd,
  output logic [31:0]          to_reg_wdata,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_tag
);

  localparam int unsigned DEPTH  = 2 ** ROB_WIDTH;
  localparam int unsigned CNT_W  = ROB_WIDTH + 1;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic              has_rd;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t [DEPTH-1:0]   rob_q, rob_d;
  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 to_reg_wen_q, to_reg_wen_d;
  logic [RD_W-1:0]      to_reg_rd_q, to_reg_rd_d;
  logic [DATA_W-1:0]    to_reg_wdata_q, to_reg_wdata_d;
  logic                 commit_valid_q, commit_valid_d;
  logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
  logic                 issue_fire;
  logic                 commit_fire;

  // Status flags come from registered count, so a same-cycle retire never frees room.
  assign issue_tag   = tail_q;
  assign rob_full    = (count_q == CNT_W'(DEPTH));
  assign rob_empty   = (count_q == '0);
  assign issue_fire  = issue_valid && !rob_full;
  assign commit_fire = rob_q[head_q].busy && rob_q[head_q].ready;

  assign to_reg_wen   = to_reg_wen_q;
  assign to_reg_rd    = to_reg_rd_q;
  assign to_reg_wdata = to_reg_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;

  // Next-state: flush beats everything; issue, CDB capture and retire are independent.
  always_comb begin
    rob_d          = rob_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    to_reg_wen_d   = 1'b0;
    commit_valid_d = 1'b0;
    to_reg_rd_d    = to_reg_rd_q;
    to_reg_wdata_d = to_reg_wdata_q;
    commit_tag_d   = commit_tag_q;

    if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < DEPTH; i++) begin
          rob_d[i].busy  = 1'b0;
          rob_d[i].ready = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (issue_fire) begin
          rob_d[tail_q].busy   = 1'b1;
          rob_d[tail_q].ready  = 1'b0;
          rob_d[tail_q].has_rd = issue_has_rd;
          rob_d[tail_q].rd     = issue_rd;
          tail_d               = tail_q + ROB_WIDTH'(1);
        end

        // Broadcasts for entries that are not in flight are stale and ignored.
        if (cdb_valid && rob_q[cdb_tag].busy) begin
          rob_d[cdb_tag].ready = 1'b1;
          rob_d[cdb_tag].value = cdb_value;
        end

        // Retire decision uses registered flags; applied last so busy clears.
        if (commit_fire) begin
          rob_d[head_q].busy = 1'b0;
          head_d             = head_q + ROB_WIDTH'(1);
          commit_valid_d     = 1'b1;
          commit_tag_d       = head_q;
          to_reg_wen_d       = rob_q[head_q].has_rd && (rob_q[head_q].rd != '0);
          to_reg_rd_d        = rob_q[head_q].rd;
          to_reg_wdata_d     = rob_q[head_q].value;
        end

        count_d = count_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      to_reg_wen_q   <= 1'b0;
      to_reg_rd_q    <= '0;
      to_reg_wdata_q <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
    end else begin
      rob_q          <= rob_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      to_reg_wen_q   <= to_reg_wen_d;
      to_reg_rd_q    <= to_reg_rd_d;
      to_reg_wdata_q <= to_reg_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_commit.sv
// Testbench for reorder_buffer_commit: directed stimulus with a commit scoreboard.
module tb_reorder_buffer_commit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        issue_valid;
  logic        issue_has_rd;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_tag;
  logic        rob_full;
  logic        rob_empty;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        to_reg_wen;
  logic [4:0]  to_reg_rd;
  logic [31:0] to_reg_wdata;
  logic        commit_valid;
  logic [2:0]  commit_tag;

  typedef struct packed {
    logic [2:0]  tag;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] val_of_tag [8];
  logic [2:0]  exp_tail;
  int          n_chk     = 0;
  int          n_fail    = 0;
  int          n_commits = 0;

  reorder_buffer_commit #(.ROB_WIDTH(3)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .issue_valid  (issue_valid),
    .issue_has_rd (issue_has_rd),
    .issue_rd     (issue_rd),
    .issue_tag    (issue_tag),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .to_reg_wen   (to_reg_wen),
    .to_reg_rd    (to_reg_rd),
    .to_reg_wdata (to_reg_wdata),
    .commit_valid (commit_valid),
    .commit_tag   (commit_tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every retire pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (commit_valid) begin
        n_commits++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_commit: got tag %0d expected none (t=%0t)", commit_tag, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_tag",   32'(commit_tag), 32'(e.tag));
          chk("to_reg_wen",   32'(to_reg_wen), 32'(e.wen));
          chk("to_reg_rd",    32'(to_reg_rd),  32'(e.rd));
          chk("to_reg_wdata", to_reg_wdata,    e.data);
        end
      end else if (to_reg_wen) begin
        chk("wen_without_commit", 32'(to_reg_wen), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    rst_in = 1'b1;
    tick();
    rst_in   = 1'b0;
    exp_tail = 3'd0;
  endtask

  task automatic do_issue(input logic has_rd, input logic [4:0] rd, input logic [31:0] val,
                          input logic accept);
    exp_t e;
    chk("issue_tag_pre", 32'(issue_tag), 32'(exp_tail));
    chk("rob_full_pre",  32'(rob_full),  32'(!accept));
    issue_valid  = 1'b1;
    issue_has_rd = has_rd;
    issue_rd     = rd;
    if (accept) begin
      e.tag  = exp_tail;
      e.wen  = has_rd && (rd != 5'd0);
      e.rd   = rd;
      e.data = val;
      exp_q.push_back(e);
      val_of_tag[exp_tail] = val;
      exp_tail = exp_tail + 3'd1;
    end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [2:0] tag);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val_of_tag[tag];
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (!rob_empty && n < budget) begin
      tick();
      n++;
    end
    if (!rob_empty) chk("wait_empty_timeout", 32'(rob_empty), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_in = 1'b1; rdy_in = 1'b0; clear_in = 1'b0;
    issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = 5'd0;
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_value = 32'd0;
    exp_tail = 3'd0;
    for (int i = 0; i < 8; i++) val_of_tag[i] = 32'd0;

    // 1: reset applies even with rdy_in low
    tick(); tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    chk("rst_empty",  32'(rob_empty),    32'd1);
    chk("rst_full",   32'(rob_full),     32'd0);
    chk("rst_tag",    32'(issue_tag),    32'd0);
    chk("rst_wen",    32'(to_reg_wen),   32'd0);
    chk("rst_cv",     32'(commit_valid), 32'd0);
    chk("rst_wdata",  to_reg_wdata,      32'd0);

    // 2: single instruction, CDB at head retires two edges later
    do_issue(1'b1, 5'd5, 32'h1234, 1'b1);
    do_cdb(3'd0);
    chk("t2_no_commit_yet", 32'(commit_valid), 32'd0);
    tick();
    chk("t2_cv",    32'(commit_valid), 32'd1);
    chk("t2_wen",   32'(to_reg_wen),   32'd1);
    chk("t2_rd",    32'(to_reg_rd),    32'd5);
    chk("t2_wdata", to_reg_wdata,      32'h1234);
    tick();
    chk("t2_cv_single",  32'(commit_valid), 32'd0);
    chk("t2_wen_single", 32'(to_reg_wen),   32'd0);
    chk("t2_empty",      32'(rob_empty),    32'd1);

    // 3: out-of-order completion, in-order retire
    do_reset();
    do_issue(1'b1, 5'd1, 32'h11, 1'b1);
    do_issue(1'b1, 5'd2, 32'h22, 1'b1);
    do_issue(1'b1, 5'd3, 32'h33, 1'b1);
    do_cdb(3'd2);
    do_cdb(3'd1);
    chk("t3_held_by_head", 32'(commit_valid), 32'd0);
    do_cdb(3'd0);
    chk("t3_cv0", 32'(commit_valid), 32'd0);
    tick(); chk("t3_tag0", 32'(commit_tag), 32'd0); chk("t3_cv1", 32'(commit_valid), 32'd1);
    tick(); chk("t3_tag1", 32'(commit_tag), 32'd1); chk("t3_cv2", 32'(commit_valid), 32'd1);
    tick(); chk("t3_tag2", 32'(commit_tag), 32'd2); chk("t3_cv3", 32'(commit_valid), 32'd1);
    tick(); chk("t3_empty", 32'(rob_empty), 32'd1);

    // 4: fill, overflow drop, wrap
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(1'b1, 5'(8 + i), 32'h400 + 32'(i), 1'b1);
    chk("t4_full", 32'(rob_full), 32'd1);
    do_issue(1'b1, 5'd30, 32'hdead, 1'b0);
    chk("t4_tag_after_drop", 32'(issue_tag), 32'd0);
    do_cdb(3'd0);
    // Head retires on this edge; issue is still refused (no bypass).
    do_issue(1'b1, 5'd31, 32'hbeef, 1'b0);
    chk("t4_not_full", 32'(rob_full),  32'd0);
    chk("t4_wrap_tag", 32'(issue_tag), 32'd0);
    do_issue(1'b1, 5'd20, 32'h5a5a, 1'b1);
    chk("t4_full_again", 32'(rob_full), 32'd1);
    chk("t4_tail_wrap",  32'(issue_tag), 32'd1);
    for (int i = 1; i < 8; i++) do_cdb(3'(i));
    do_cdb(3'd0);
    wait_empty(20);

    // 5: x0 destination and no destination retire without writing
    do_reset();
    c0 = n_commits;
    do_issue(1'b1, 5'd0, 32'haa, 1'b1);
    do_issue(1'b0, 5'd7, 32'hbb, 1'b1);
    do_cdb(3'd1);
    do_cdb(3'd0);
    wait_empty(10);
    chk("t5_two_commits", 32'(n_commits - c0), 32'd2);

    // 6: flush discards everything including same-cycle traffic
    do_reset();
    do_issue(1'b1, 5'd1, 32'h61, 1'b1);
    do_issue(1'b1, 5'd2, 32'h62, 1'b1);
    do_issue(1'b1, 5'd3, 32'h63, 1'b1);
    do_cdb(3'd0);
    clear_in = 1'b1; issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd4;
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'h62;
    tick();
    clear_in = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0;
    exp_q.delete();
    exp_tail = 3'd0;
    chk("t6_no_commit", 32'(commit_valid), 32'd0);
    chk("t6_empty",     32'(rob_empty),    32'd1);
    chk("t6_tag",       32'(issue_tag),    32'd0);
    do_cdb(3'd1);
    tick();
    chk("t6_stale_cdb_empty", 32'(rob_empty),    32'd1);
    chk("t6_stale_cdb_cv",    32'(commit_valid), 32'd0);

    // 6b: rdy_in low freezes state while a retire is pending
    do_issue(1'b1, 5'd9, 32'h99, 1'b1);
    do_cdb(3'd0);
    rdy_in = 1'b0; issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frz_cv",    32'(commit_valid), 32'd0);
      chk("t6_frz_tag",   32'(issue_tag),    32'd1);
      chk("t6_frz_empty", 32'(rob_empty),    32'd0);
    end
    rdy_in = 1'b1; issue_valid = 1'b0;
    tick();
    chk("t6_thaw_cv",    32'(commit_valid), 32'd1);
    chk("t6_thaw_empty", 32'(rob_empty),    32'd1);
    rdy_in = 1'b0;
    tick();
    chk("t6_pulse_cleared", 32'(commit_valid), 32'd0);
    chk("t6_wen_cleared",   32'(to_reg_wen),   32'd0);
    chk("t6_wdata_holds",   to_reg_wdata,      32'h99);
    rdy_in = 1'b1;
    tick();
    chk("scoreboard_final", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
